// File: rtl/hdmi_pkg.sv
// rtl/hdmi_pkg.sv - shared encodings, addresses, bar colours and reset defaults
package hdmi_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID   = 2'd0,
    MODE_BARS    = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_BOX     = 2'd3
  } mode_e;

  typedef struct packed {
    mode_e       mode;
    logic [23:0] color;
    logic [7:0]  size;
    logic [3:0]  step;
  } cfg_t;

  localparam logic [1:0] ADDR_MODE  = 2'd0;
  localparam logic [1:0] ADDR_COLOR = 2'd1;
  localparam logic [1:0] ADDR_BOX   = 2'd2;

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  localparam cfg_t RST_CFG = '{mode: MODE_BARS, color: 24'hFFFFFF, size: 8'd32, step: 4'd2};

  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/hdmi_bounce_axis.sv
// rtl/hdmi_bounce_axis.sv - one axis of the bouncing box: position and direction
module hdmi_bounce_axis #(
  parameter int LIMIT = 1280
) (
  input  logic        clk_pix,
  input  logic        rst_n,
  input  logic        en,
  input  logic [7:0]  size,
  input  logic [3:0]  step,
  output logic [11:0] pos
);

  logic        dir_neg;
  logic [12:0] lim;
  logic [12:0] pos_w;
  logic [12:0] step_w;
  logic [12:0] plus;

  // 13-bit working width keeps pos+step and LIMIT-size from wrapping
  always_comb begin
    lim    = 13'(LIMIT) - {5'd0, size};
    pos_w  = {1'b0, pos};
    step_w = {9'd0, step};
    plus   = pos_w + step_w;
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      pos     <= 12'd0;
      dir_neg <= 1'b0;
    end else if (en) begin
      if (!dir_neg) begin
        if (plus > lim) begin
          pos     <= lim[11:0];
          dir_neg <= 1'b1;
        end else begin
          pos <= plus[11:0];
        end
      end else begin
        if (step_w > pos_w) begin
          pos     <= 12'd0;
          dir_neg <= 1'b0;
        end else begin
          pos <= pos - {8'd0, step};
        end
      end
    end
  end

endmodule

// File: rtl/hdmi_pattern_gen.sv
// rtl/hdmi_pattern_gen.sv - test pattern source with frame-synchronous config apply
module hdmi_pattern_gen
  import hdmi_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720
) (
  input  logic        clk_pix,
  input  logic        rst_n,
  input  logic [11:0] h_pos,
  input  logic [11:0] v_pos,
  output logic [23:0] data,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic        cfg_pending,
  output logic [15:0] frame_cnt
);

  localparam int BAR_W = H_ACTIVE / 8;

  cfg_t        stg_q;
  cfg_t        act_q;
  cfg_t        eff_cfg;
  logic [11:0] prev_v_q;
  logic [15:0] frame_cnt_q;
  logic        frame_start;
  logic        cfg_valid;
  logic        box_en;
  logic [11:0] box_x;
  logic [11:0] box_y;
  logic        unused_wdata;

  assign unused_wdata = ^cfg_wdata[31:24];
  assign frame_cnt    = frame_cnt_q;

  // Box update on an applying frame start must see the config being applied
  always_comb begin
    frame_start = (v_pos == 12'd0) && (prev_v_q != 12'd0);
    cfg_valid   = cfg_we && (cfg_addr != 2'd3);
    eff_cfg     = frame_start ? stg_q : act_q;
    box_en      = frame_start && (eff_cfg.mode == MODE_BOX) && (eff_cfg.step != 4'd0);
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      stg_q       <= RST_CFG;
      act_q       <= RST_CFG;
      cfg_pending <= 1'b0;
      frame_cnt_q <= 16'd0;
      prev_v_q    <= 12'd0;
    end else begin
      prev_v_q <= v_pos;
      if (frame_start) begin
        act_q       <= stg_q;
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      if (cfg_valid) begin
        case (cfg_addr)
          ADDR_MODE:  stg_q.mode  <= mode_e'(cfg_wdata[1:0]);
          ADDR_COLOR: stg_q.color <= cfg_wdata[23:0];
          default: begin
            stg_q.size <= cfg_wdata[7:0];
            stg_q.step <= cfg_wdata[11:8];
          end
        endcase
        cfg_pending <= 1'b1;
      end else if (frame_start) begin
        cfg_pending <= 1'b0;
      end
    end
  end

  hdmi_bounce_axis #(.LIMIT(H_ACTIVE)) u_box_x (
    .clk_pix (clk_pix),
    .rst_n   (rst_n),
    .en      (box_en),
    .size    (eff_cfg.size),
    .step    (eff_cfg.step),
    .pos     (box_x)
  );

  hdmi_bounce_axis #(.LIMIT(V_ACTIVE)) u_box_y (
    .clk_pix (clk_pix),
    .rst_n   (rst_n),
    .en      (box_en),
    .size    (eff_cfg.size),
    .step    (eff_cfg.step),
    .pos     (box_y)
  );

  logic [2:0]  bar_idx;
  logic [12:0] h_w;
  logic [12:0] v_w;
  logic [12:0] size_w;
  logic        in_box;

  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (h_pos >= 12'(k * BAR_W)) bar_idx = 3'(k);
    end
    h_w    = {1'b0, h_pos};
    v_w    = {1'b0, v_pos};
    size_w = {5'd0, act_q.size};
    in_box = (h_w >= {1'b0, box_x}) && (h_w < {1'b0, box_x} + size_w) &&
             (v_w >= {1'b0, box_y}) && (v_w < {1'b0, box_y} + size_w);
    data = 24'h000000;
    case (act_q.mode)
      MODE_SOLID:   data = act_q.color;
      MODE_BARS:    data = bar_color(bar_idx);
      MODE_CHECKER: data = (h_pos[5] ^ v_pos[5]) ? 24'h000000 : act_q.color;
      MODE_BOX:     data = in_box ? act_q.color : 24'h000000;
      default:      data = 24'h000000;
    endcase
  end

endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// tb/tb_hdmi_pattern_gen.sv - self-checking bench against a behavioural model
module tb_hdmi_pattern_gen;

  localparam int H = 1280;
  localparam int V = 720;

  logic        clk_pix = 1'b0;
  logic        rst_n;
  logic [11:0] h_pos;
  logic [11:0] v_pos;
  logic [23:0] data;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        cfg_pending;
  logic [15:0] frame_cnt;

  always #5 clk_pix = ~clk_pix;

  hdmi_pattern_gen #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk_pix     (clk_pix),
    .rst_n       (rst_n),
    .h_pos       (h_pos),
    .v_pos       (v_pos),
    .data        (data),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .cfg_pending (cfg_pending),
    .frame_cnt   (frame_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  int bars[8] = '{32'hFFFFFF, 32'hFFFF00, 32'h00FFFF, 32'h00FF00,
                  32'hFF00FF, 32'hFF0000, 32'h0000FF, 32'h000000};

  // staging (s_*) and active (a_*) views of the config
  int s_mode, s_color, s_size, s_step;
  int a_mode, a_color, a_size, a_step;
  int m_pend, m_fcnt, m_prev;
  int m_bx, m_by, m_dx, m_dy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    s_mode = 1; s_color = 32'hFFFFFF; s_size = 32; s_step = 2;
    a_mode = 1; a_color = 32'hFFFFFF; a_size = 32; a_step = 2;
    m_pend = 0; m_fcnt = 0; m_prev = 0;
    m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1;
  endfunction

  function automatic void bounce(inout int pos, inout int dir, input int step, input int lim);
    pos = pos + dir * step;
    if (dir > 0 && pos > lim) begin
      pos = lim; dir = -1;
    end else if (pos < 0) begin
      pos = 0; dir = 1;
    end
  endfunction

  function automatic int exp_data(input int h, input int v);
    int idx;
    case (a_mode)
      0: return a_color;
      1: begin
        idx = h / (H / 8);
        if (idx > 7) idx = 7;
        return bars[idx];
      end
      2: return (((h / 32) % 2) == ((v / 32) % 2)) ? a_color : 0;
      default:
        return (h >= m_bx && h < m_bx + a_size && v >= m_by && v < m_by + a_size) ? a_color : 0;
    endcase
  endfunction

  function automatic void model_edge(input int v, input bit we, input int addr, input int wdata);
    bit fs;
    fs = (v == 0) && (m_prev != 0);
    if (fs) begin
      a_mode = s_mode; a_color = s_color; a_size = s_size; a_step = s_step;
      m_fcnt = (m_fcnt + 1) % 65536;
      if (a_mode == 3) begin
        bounce(m_bx, m_dx, a_step, H - a_size);
        bounce(m_by, m_dy, a_step, V - a_size);
      end
    end
    if (we && addr != 3) begin
      if (addr == 0) s_mode = wdata & 3;
      else if (addr == 1) s_color = wdata & 32'hFFFFFF;
      else begin
        s_size = wdata & 255;
        s_step = (wdata >> 8) & 15;
      end
      m_pend = 1;
    end else if (fs) begin
      m_pend = 0;
    end
    m_prev = v;
  endfunction

  // One clock: drive, check outputs against the model, clock, advance the model
  task automatic cyc(input int h, input int v, input bit we, input int addr, input int wdata);
    h_pos = 12'(h); v_pos = 12'(v);
    cfg_we = we; cfg_addr = 2'(addr); cfg_wdata = 32'(wdata);
    #1;
    chk("data", {8'd0, data}, 32'(exp_data(h, v)));
    chk("cfg_pending", {31'd0, cfg_pending}, 32'(m_pend));
    chk("frame_cnt", {16'd0, frame_cnt}, 32'(m_fcnt));
    @(posedge clk_pix);
    model_edge(v, we, addr, wdata);
    @(negedge clk_pix);
    cfg_we = 1'b0;
  endtask

  task automatic pix(input string tag, input int h, input int v, input logic [23:0] exp);
    h_pos = 12'(h); v_pos = 12'(v);
    #1;
    chk(tag, {8'd0, data}, {8'd0, exp});
  endtask

  initial begin
    int h, v, hp;
    rst_n = 1'b0; h_pos = '0; v_pos = 12'd5;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    model_reset();
    repeat (3) @(negedge clk_pix);
    chk("rst_pending", {31'd0, cfg_pending}, 32'd0);
    chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk_pix);

    pix("bar_h0", 0, 5, 24'hFFFFFF);
    pix("bar_h160", 160, 5, 24'hFFFF00);
    pix("bar_h1279", 1279, 5, 24'h000000);
    for (int i = 0; i < 8; i++) cyc(i * 160 + 80, 5, 0, 0, 0);

    // staged solid colour must not show until the next frame start
    cyc(10, 5, 1, 0, 0);
    cyc(10, 5, 1, 1, 32'h123456);
    pix("stage_hold_bars", 0, 5, 24'hFFFFFF);
    chk("stage_pending", {31'd0, cfg_pending}, 32'd1);
    cyc(300, 6, 0, 0, 0);
    cyc(300, 0, 0, 0, 0);
    pix("solid_applied", 200, 9, 24'h123456);
    chk("pending_cleared", {31'd0, cfg_pending}, 32'd0);

    cyc(0, 7, 1, 0, 2);
    cyc(0, 7, 1, 1, 32'h00FF00);
    cyc(0, 7, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    pix("chk_0_0", 0, 0, 24'h00FF00);
    pix("chk_32_0", 32, 0, 24'h000000);
    pix("chk_32_32", 32, 32, 24'h00FF00);
    for (int i = 0; i < 16; i++) cyc($urandom_range(0, H - 1), $urandom_range(1, V - 1), 0, 0, 0);

    // write landing exactly on the frame-start cycle
    cyc(5, 4, 1, 0, 0);
    cyc(5, 4, 0, 0, 0);
    cyc(5, 0, 1, 1, 32'hABCDEF);
    pix("coinc_old_applied", 100, 100, 24'h00FF00);
    chk("coinc_pending", {31'd0, cfg_pending}, 32'd1);
    cyc(5, 4, 0, 0, 0);
    cyc(5, 0, 0, 0, 0);
    pix("coinc_new_applied", 100, 100, 24'hABCDEF);
    chk("coinc_pending_clr", {31'd0, cfg_pending}, 32'd0);

    // bouncing box over 700 frames, probing inside and at both x edges
    cyc(0, 3, 1, 0, 3);
    cyc(0, 3, 1, 2, 32'h0220);
    cyc(0, 3, 1, 1, 32'h3355AA);
    cyc(0, 0, 0, 0, 0);
    for (int f = 0; f < 700; f++) begin
      if (m_bx == 1248) begin
        pix("peak_x_in", 1248, m_by + 1, 24'h3355AA);
        pix("peak_x_left", 1247, m_by + 1, 24'h000000);
      end
      if (m_by == 688) pix("peak_y_in", m_bx, 719, 24'h3355AA);
      cyc(m_bx + $urandom_range(0, 31), m_by + 1 + $urandom_range(0, 30), 0, 0, 0);
      cyc(m_bx + 32, m_by + 1, 0, 0, 0);
      if (m_bx > 0) cyc(m_bx - 1, m_by + 1, 0, 0, 0);
      cyc($urandom_range(0, H - 1), 0, 0, 0, 0);
    end

    // randomized traffic: random pixels, frame starts and config writes
    for (int i = 0; i < 600; i++) begin
      h = $urandom_range(0, H - 1);
      v = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, V - 1);
      if ($urandom_range(0, 3) == 0)
        cyc(h, v, 1, $urandom_range(0, 3), $urandom);
      else
        cyc(h, v, 0, 0, 0);
    end

    // frame counter wrap
    @(negedge clk_pix);
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    m_fcnt = 65535;
    chk("fcnt_forced", {16'd0, frame_cnt}, 32'h0000FFFF);
    @(negedge clk_pix);
    cyc(0, 2, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("fcnt_wrap", {16'd0, frame_cnt}, 32'd0);

    // reset mid-frame discards staged config and the pending frame start
    cyc(0, 2, 1, 0, 0);
    cyc(0, 9, 0, 0, 0);
    hp = 160;
    rst_n = 1'b0;
    model_reset();
    pix("mrst_bar0", 0, 5, 24'hFFFFFF);
    pix("mrst_bar1", hp, 5, 24'hFFFF00);
    chk("mrst_pending", {31'd0, cfg_pending}, 32'd0);
    chk("mrst_fcnt", {16'd0, frame_cnt}, 32'd0);
    @(negedge clk_pix);
    rst_n = 1'b1;
    v_pos = 12'd0;
    @(negedge clk_pix);
    cyc(0, 0, 0, 0, 0);
    chk("mrst_no_frame", {16'd0, frame_cnt}, 32'd0);
    cyc(0, 3, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("mrst_frame", {16'd0, frame_cnt}, 32'd1);
    pix("mrst_staged_dropped", hp, 5, 24'hFFFF00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hdmi_pattern_gen.md
HDMI_PATTERN_GEN -- requirements
Module: hdmi_pattern_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1280, active pixels per line (must be a multiple of 8).
REQ-002 SHALL have parameter V_ACTIVE, default 720, active lines per frame.
REQ-003 SHALL have port clk_pix, input, 1, pixel clock; the only clock.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port h_pos, input, 12, active-area column from the hdmi block.
REQ-006 SHALL have port v_pos, input, 12, active-area row from the hdmi block.
REQ-007 SHALL have port data, output, 24, RGB888 pixel to the hdmi data input ({R,G,B}).
REQ-008 SHALL have port cfg_we, input, 1, configuration write strobe, one cycle.
REQ-009 SHALL have port cfg_addr, input, 2, register select.
REQ-010 SHALL have port cfg_wdata, input, 32, write data.
REQ-011 SHALL have port cfg_pending, output, 1, staged config not yet applied.
REQ-012 SHALL have port frame_cnt, output, 16, frames completed since reset.

Function
REQ-013 SHALL drive data combinationally from h_pos, v_pos and the active registers, with zero cycles of latency relative to h_pos and v_pos.
REQ-014 SHALL detect frame start on the first cycle where v_pos==0 while the registered previous v_pos!=0.
REQ-015 SHALL implement the following staging registers:
- addr0 MODE[1:0]: 0 solid, 1 colour bars, 2 checker, 3 bouncing box.
- addr1 COLOR[23:0].
- addr2 BOX: SIZE[7:0] and STEP[11:8].
- addr3: writes ignored.
REQ-016 SHALL capture a write to addr0–2 into staging and set cfg_pending=1 on the next clock edge.
REQ-017 SHALL copy staging to active and clear cfg_pending at frame start.
REQ-018 SHALL, when a write coincides with frame start, apply the old staging contents, store the new write in staging, and leave cfg_pending=1.
REQ-019 SHALL increment frame_cnt at each frame start, wrapping from 0xFFFF to 0.
REQ-020 SHALL output COLOR everywhere in solid mode.
REQ-021 SHALL, in colour-bar mode, divide the line into 8 bars of width H_ACTIVE/8 (comparisons against constants, no divider), coloured left to right: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
REQ-022 SHALL, in checker mode, output COLOR when h_pos[5]^v_pos[5]==0 and 000000 otherwise.
REQ-023 SHALL, in box mode, output COLOR when box_x<=h_pos<box_x+SIZE and box_y<=v_pos<box_y+SIZE, and 000000 otherwise.
REQ-024 SHALL update box_x at each frame start in box mode as box_x ± STEP according to direction dir_x:
- If the +dir result exceeds H_ACTIVE−SIZE, clamp to H_ACTIVE−SIZE and set dir_x to −.
- If the −dir result would go below 0, clamp to 0 and set dir_x to +.
REQ-025 SHALL update box_y and dir_y identically, using V_ACTIVE.
REQ-026 SHALL evaluate the box update using the newly applied SIZE and STEP when a config apply coincides with frame start.
REQ-027 SHALL freeze the box position when not in box mode, and SHALL leave the box stationary when STEP==0.
REQ-028 SHALL perform all box arithmetic in 13 bits, so that no intermediate value wraps.

Reset
REQ-029 SHALL, while rst_n is low, asynchronously set:
- active and staging MODE=1, COLOR=FFFFFF, SIZE=32, STEP=2;
- box_x=0, box_y=0, dir_x=+, dir_y=+;
- frame_cnt=0, cfg_pending=0, previous v_pos=0.
REQ-030 SHALL, when reset is asserted mid-frame, discard staged writes, and SHALL not count a frame start until a v_pos nonzero-to-zero transition is seen after release.

Structure
REQ-031 SHALL place the mode encodings, register addresses, bar colour constants and reset defaults in shared package hdmi_pkg.
REQ-032 SHALL implement the box position and direction update as sub-module hdmi_bounce_axis, instantiated once per axis with a LIMIT parameter.

Verification
REQ-033 SHALL cover: after reset, h_pos=0/160/1279 at v_pos=5 -> data=FFFFFF/FFFF00/000000.
REQ-034 SHALL cover: write MODE=0 and COLOR=123456 mid-frame -> cfg_pending=1, data unchanged (bars) until the frame start, then data=123456 and cfg_pending=0.
REQ-035 SHALL cover: MODE=2, COLOR=00FF00 -> (0,0)=00FF00, (32,0)=000000, (32,32)=00FF00.
REQ-036 SHALL cover: MODE=3, SIZE=32, STEP=2, run 700 frames -> box_x peaks at 1248 and dir_x flips, box_y peaks at 688, and data inside the box is COLOR.
REQ-037 SHALL cover: cfg_we asserted on the frame-start cycle -> prior staging applied, new value applied one frame later, cfg_pending high in between.
REQ-038 SHALL cover: frame_cnt forced to 0xFFFF, one frame start -> frame_cnt=0; rst_n pulsed mid-frame -> all REQ-029 values restored.
